// File: rtl/decode_stage.sv
// Instruction decode stage: classifies the opcode one-hot, holds raw fields, counts illegal opcodes.
// Latency: one cycle from input acceptance to presentation at the outputs.
// Backpressure: two-entry skid buffer with registered in_ready (SKID_EN=1), or a single register (SKID_EN=0).
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 8,
  parameter int SKID_EN = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_insn,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [10:0]      o_ctrl,
  output logic             o_illegal,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs,
  output logic [4:0]       o_rt,
  output logic [4:0]       o_shamt,
  output logic [4:0]       o_aluop,
  output logic [XLEN-1:0]  o_imm,
  output logic [XLEN-1:0]  o_target,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  // Opcode is consumed by the decoder, so entries only keep bits [26:0].
  logic [10:0]      w_dec_ctrl;
  logic             w_dec_ill;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_vld_nxt;
  logic             w_skid_vld_nxt;
  logic             w_ld_main_in;
  logic             w_ld_main_skid;
  logic             w_ld_skid;

  logic             r_main_vld;
  logic [26:0]      r_main_insn;
  logic [10:0]      r_main_ctrl;
  logic             r_main_ill;
  logic             r_skid_vld;
  logic [26:0]      r_skid_insn;
  logic [10:0]      r_skid_ctrl;
  logic             r_skid_ill;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_cnt;

  // Opcode to one-hot class; bit0 = rtype up to bit10 = setx.
  always_comb begin
    w_dec_ctrl = '0;
    w_dec_ill  = 1'b0;
    case (i_insn[31:27])
      5'b00000: w_dec_ctrl[0]  = 1'b1; // rtype
      5'b00101: w_dec_ctrl[1]  = 1'b1; // addi
      5'b00111: w_dec_ctrl[2]  = 1'b1; // sw
      5'b01000: w_dec_ctrl[3]  = 1'b1; // lw
      5'b00001: w_dec_ctrl[4]  = 1'b1; // j
      5'b00010: w_dec_ctrl[5]  = 1'b1; // bne
      5'b00011: w_dec_ctrl[6]  = 1'b1; // jal
      5'b00100: w_dec_ctrl[7]  = 1'b1; // jr
      5'b00110: w_dec_ctrl[8]  = 1'b1; // blt
      5'b10110: w_dec_ctrl[9]  = 1'b1; // bex
      5'b10101: w_dec_ctrl[10] = 1'b1; // setx
      default:  w_dec_ill      = 1'b1;
    endcase
  end

  assign w_in_xfer  = i_in_valid & o_in_ready;
  assign w_out_xfer = r_main_vld & i_out_ready;

  // Occupancy transitions; flush overrides everything and drops any incoming entry.
  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (i_flush) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (r_skid_vld) begin
      if (w_out_xfer) begin
        w_ld_main_skid = 1'b1;
        w_skid_vld_nxt = 1'b0;
      end
    end else if (r_main_vld) begin
      if (w_in_xfer && w_out_xfer) begin
        w_ld_main_in = 1'b1;
      end else if (w_out_xfer) begin
        w_main_vld_nxt = 1'b0;
      end else if (w_in_xfer && (SKID_EN != 0)) begin
        w_ld_skid      = 1'b1;
        w_skid_vld_nxt = 1'b1;
      end
    end else if (w_in_xfer) begin
      w_ld_main_in   = 1'b1;
      w_main_vld_nxt = 1'b1;
    end
  end

  // Entry registers, registered ready and the saturating illegal counter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_main_vld  <= 1'b0;
      r_main_insn <= '0;
      r_main_ctrl <= '0;
      r_main_ill  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_insn <= '0;
      r_skid_ctrl <= '0;
      r_skid_ill  <= 1'b0;
      r_in_rdy    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_in_rdy   <= (SKID_EN != 0) ? !w_skid_vld_nxt : 1'b1;
      if (w_ld_main_in) begin
        r_main_insn <= i_insn[26:0];
        r_main_ctrl <= w_dec_ctrl;
        r_main_ill  <= w_dec_ill;
      end else if (w_ld_main_skid) begin
        r_main_insn <= r_skid_insn;
        r_main_ctrl <= r_skid_ctrl;
        r_main_ill  <= r_skid_ill;
      end
      if (w_ld_skid) begin
        r_skid_insn <= i_insn[26:0];
        r_skid_ctrl <= w_dec_ctrl;
        r_skid_ill  <= w_dec_ill;
      end
      // Counts every accepted illegal word, even one dropped by a same-cycle flush.
      if (w_in_xfer && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Without a skid, ready also opens when the held entry leaves this cycle.
  always_comb begin
    if (SKID_EN != 0) o_in_ready = r_in_rdy;
    else              o_in_ready = r_in_rdy & (!r_main_vld | i_out_ready);
  end

  assign o_out_valid   = r_main_vld;
  assign o_ctrl        = r_main_vld ? r_main_ctrl : 11'd0;
  assign o_illegal     = r_main_vld & r_main_ill;
  assign o_rd          = r_main_insn[26:22];
  assign o_rs          = r_main_insn[21:17];
  assign o_rt          = r_main_insn[16:12];
  assign o_shamt       = r_main_insn[11:7];
  assign o_aluop       = r_main_insn[6:2];
  assign o_imm         = {{(XLEN-17){r_main_insn[16]}}, r_main_insn[16:0]};
  assign o_target      = {{(XLEN-27){1'b0}}, r_main_insn[26:0]};
  assign o_illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a queue model.
// Instance a: XLEN=64, CNT_W=2, skid buffer on. Instance b: defaults with skid buffer off.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [31:0] a_insn = 0;
  logic        a_in_ready, a_out_valid, a_illegal;
  logic [10:0] a_ctrl;
  logic [4:0]  a_rd, a_rs, a_rt, a_shamt, a_aluop;
  logic [63:0] a_imm, a_target;
  logic [1:0]  a_cnt;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [31:0] b_insn = 0;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [10:0] b_ctrl;
  logic [4:0]  b_rd, b_rs, b_rt, b_shamt, b_aluop;
  logic [31:0] b_imm, b_target;
  logic [7:0]  b_cnt;

  decode_stage #(.XLEN(64), .CNT_W(2), .SKID_EN(1)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_flush(a_flush), .i_in_valid(a_in_valid),
    .o_in_ready(a_in_ready), .i_insn(a_insn), .o_out_valid(a_out_valid),
    .i_out_ready(a_out_ready), .o_ctrl(a_ctrl), .o_illegal(a_illegal),
    .o_rd(a_rd), .o_rs(a_rs), .o_rt(a_rt), .o_shamt(a_shamt), .o_aluop(a_aluop),
    .o_imm(a_imm), .o_target(a_target), .o_illegal_cnt(a_cnt));

  decode_stage #(.XLEN(32), .CNT_W(8), .SKID_EN(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_flush(b_flush), .i_in_valid(b_in_valid),
    .o_in_ready(b_in_ready), .i_insn(b_insn), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready), .o_ctrl(b_ctrl), .o_illegal(b_illegal),
    .o_rd(b_rd), .o_rs(b_rs), .o_rt(b_rt), .o_shamt(b_shamt), .o_aluop(b_aluop),
    .o_imm(b_imm), .o_target(b_target), .o_illegal_cnt(b_cnt));

  // Opcode owning each ctrl bit, bit0 (rtype) first.
  logic [4:0] class_op [11] = '{5'd0, 5'd5, 5'd7, 5'd8, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd22, 5'd21};

  function automatic logic [10:0] ref_ctrl(input logic [31:0] w);
    logic [10:0] c;
    c = '0;
    for (int i = 0; i < 11; i++) if (w[31:27] == class_op[i]) c[i] = 1'b1;
    return c;
  endfunction

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_insn = 0;
    b_flush = 0; b_in_valid = 0; b_insn = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk); #1;
    total++; if (a_out_valid !== 1'b0 || a_ctrl !== 11'd0 || a_illegal !== 1'b0) begin bad++; $display("FAIL reset_outs: vld=%b ctrl=%h ill=%b want 0/0/0", a_out_valid, a_ctrl, a_illegal); end
    total++; if (a_cnt !== 2'd0 || a_rd !== 5'd0 || a_imm !== 64'd0 || a_target !== 64'd0) begin bad++; $display("FAIL reset_fields: cnt=%0d rd=%0d imm=%h tgt=%h want 0", a_cnt, a_rd, a_imm, a_target); end
    total++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: a=%b b=%b want 0/0", a_in_ready, b_in_ready); end
    rst = 0;
    @(posedge clk); #1;
    total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: a=%b b=%b want 1/1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_addi();
    @(negedge clk);
    a_out_ready = 1; a_in_valid = 1; a_insn = 32'h2840_0005;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b1 || a_ctrl !== 11'h002 || a_rd !== 5'd1 || a_imm !== 64'd5) begin bad++; $display("FAIL addi: vld=%b ctrl=%h rd=%0d imm=%0d want 1/002/1/5", a_out_valid, a_ctrl, a_rd, a_imm); end
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk); #1;
    total++; if (a_out_valid !== 1'b0 || a_ctrl !== 11'd0) begin bad++; $display("FAIL addi_drain: vld=%b ctrl=%h want 0/0", a_out_valid, a_ctrl); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = {5'd0, 27'h0123456}; w[1] = {5'd8, 27'h2ABCDEF}; w[2] = {5'd1, 27'h1111111};
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_insn = w[0]; #1;
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_rdy0: got %b want 1", a_in_ready); end
    @(negedge clk);
    a_insn = w[1]; #1;
    total++; if (a_in_ready !== 1'b1 || a_target[26:0] !== w[0][26:0]) begin bad++; $display("FAIL b2b_rdy1: rdy=%b tgt=%h want 1/%h", a_in_ready, a_target, w[0][26:0]); end
    @(negedge clk);
    a_insn = w[2]; #1;
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: in_ready=%b want 0", a_in_ready); end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (a_out_valid !== 1'b1 || a_target[26:0] !== w[k][26:0] || a_ctrl !== ref_ctrl(w[k])) begin bad++; $display("FAIL b2b_order%0d: vld=%b tgt=%h ctrl=%h want 1/%h/%h", k, a_out_valid, a_target, a_ctrl, w[k][26:0], ref_ctrl(w[k])); end
      @(negedge clk);
    end
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_third_dropped: vld=%b want 0", a_out_valid); end
  endtask

  task automatic test_illegal_sat();
    do_reset();
    a_out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_insn = {5'h1F, 27'(k)}; #1;
      if (k > 0) begin
        total++; if (a_out_valid !== 1'b1 || a_illegal !== 1'b1 || a_ctrl !== 11'd0 || a_target[26:0] !== 27'(k - 1) || a_cnt !== 2'((k < 3) ? k : 3)) begin bad++; $display("FAIL illegal%0d: vld=%b ill=%b ctrl=%h tgt=%0d cnt=%0d", k, a_out_valid, a_illegal, a_ctrl, a_target, a_cnt); end
      end
    end
    @(negedge clk);
    a_in_valid = 0; #1;
    total++; if (a_illegal !== 1'b1 || a_target[26:0] !== 27'd4 || a_cnt !== 2'd3) begin bad++; $display("FAIL illegal_sat: ill=%b tgt=%0d cnt=%0d want 1/4/3", a_illegal, a_target, a_cnt); end
  endtask

  task automatic test_wide();
    @(negedge clk);
    a_out_ready = 1; a_in_valid = 1; a_insn = 32'h2801_FFFF;
    @(negedge clk);
    a_insn = 32'h0C00_0000; #1;
    total++; if (a_imm !== {64{1'b1}}) begin bad++; $display("FAIL wide_imm: got %h want all ones", a_imm); end
    @(negedge clk);
    a_in_valid = 0; #1;
    total++; if (a_target !== 64'h4000000 || a_ctrl !== 11'h010) begin bad++; $display("FAIL wide_target: tgt=%h ctrl=%h want 4000000/010", a_target, a_ctrl); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_insn = {5'd2, 27'h5555};
    @(negedge clk);
    a_insn = {5'd3, 27'h6666};
    @(negedge clk); #1;
    total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin bad++; $display("FAIL flush_pre_full: rdy=%b vld=%b want 0/1", a_in_ready, a_out_valid); end
    a_flush = 1; a_insn = {5'd4, 27'h7777};
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL flush_next: vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
    @(negedge clk);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL flush_gone%0d: vld=%b tgt=%h want 0", k, a_out_valid, a_target); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_insn = {5'h1E, 27'h1};
    @(negedge clk);
    a_insn = {5'h10, 27'h2};
    @(negedge clk);
    a_in_valid = 0; #1;
    total++; if (a_out_valid !== 1'b1 || a_cnt !== 2'd2 || a_in_ready !== 1'b0) begin bad++; $display("FAIL areset_pre: vld=%b cnt=%0d rdy=%b want 1/2/0", a_out_valid, a_cnt, a_in_ready); end
    #1 rst = 1;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_cnt !== 2'd0 || a_ctrl !== 11'd0) begin bad++; $display("FAIL areset_mid: vld=%b cnt=%0d ctrl=%h want 0/0/0", a_out_valid, a_cnt, a_ctrl); end
    #1 rst = 0;
    @(posedge clk); #1;
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin bad++; $display("FAIL areset_after: vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
  endtask

  task automatic test_no_skid();
    @(negedge clk);
    b_out_ready = 0; b_in_valid = 1; b_insn = {5'd7, 27'h0AAAAAA}; #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL noskid_rdy_empty: got %b want 1", b_in_ready); end
    @(negedge clk);
    b_insn = {5'd6, 27'h0BBBBBB}; #1;
    total++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1) begin bad++; $display("FAIL noskid_block: rdy=%b vld=%b want 0/1", b_in_ready, b_out_valid); end
    b_out_ready = 1; #1;
    total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL noskid_passthru_rdy: got %b want 1", b_in_ready); end
    @(negedge clk);
    b_in_valid = 0; #1;
    total++; if (b_out_valid !== 1'b1 || b_target !== 32'h0BBBBBB || b_ctrl !== 11'h100) begin bad++; $display("FAIL noskid_replace: vld=%b tgt=%h ctrl=%h want 1/0bbbbbb/100", b_out_valid, b_target, b_ctrl); end
    @(negedge clk); #1;
    total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL noskid_drain: vld=%b want 0", b_out_valid); end
  endtask

  // Random traffic on one instance against a FIFO model of capacity 2 (a) or 1 (b).
  task automatic test_random(input bit use_b, input int cycles);
    logic [31:0] q [$];
    int          m_cnt, cnt_max;
    bit          exp_rdy, in_x, out_x, fl, iv, ordy;
    logic [31:0] w, h;
    logic        o_rdy, o_vld, o_ill;
    logic [10:0] o_ctrl;
    logic [4:0]  o_rd, o_rs, o_rt, o_sh, o_al;
    logic [63:0] o_imm, o_tgt, e_imm;
    int          o_cnt;
    do_reset();
    m_cnt   = 0;
    cnt_max = use_b ? 255 : 3;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      fl   = ($urandom % 25) == 0;
      w    = $urandom;
      if ($urandom % 2) w[31:27] = class_op[$urandom % 11];
      if (use_b) begin b_in_valid = iv; b_out_ready = ordy; b_flush = fl; b_insn = w; end
      else       begin a_in_valid = iv; a_out_ready = ordy; a_flush = fl; a_insn = w; end
      #1;
      if (use_b) begin
        o_rdy = b_in_ready; o_vld = b_out_valid; o_ill = b_illegal; o_ctrl = b_ctrl;
        o_rd = b_rd; o_rs = b_rs; o_rt = b_rt; o_sh = b_shamt; o_al = b_aluop;
        o_imm = {32'd0, b_imm}; o_tgt = {32'd0, b_target}; o_cnt = int'(b_cnt);
        exp_rdy = (q.size() == 0) || ordy;
      end else begin
        o_rdy = a_in_ready; o_vld = a_out_valid; o_ill = a_illegal; o_ctrl = a_ctrl;
        o_rd = a_rd; o_rs = a_rs; o_rt = a_rt; o_sh = a_shamt; o_al = a_aluop;
        o_imm = a_imm; o_tgt = a_target; o_cnt = int'(a_cnt);
        exp_rdy = q.size() < 2;
      end
      total++; if (o_rdy !== exp_rdy || o_vld !== (q.size() > 0) || o_cnt != m_cnt) begin bad++; $display("FAIL rand%0d_c%0d_state: rdy=%b vld=%b cnt=%0d want %b/%b/%0d", use_b, c, o_rdy, o_vld, o_cnt, exp_rdy, q.size() > 0, m_cnt); end
      if (q.size() > 0) begin
        h = q[0];
        e_imm = use_b ? {32'd0, {{15{h[16]}}, h[16:0]}} : {{47{h[16]}}, h[16:0]};
        total++; if (o_ctrl !== ref_ctrl(h) || o_ill !== (ref_ctrl(h) == 11'd0) || o_rd !== h[26:22] || o_rs !== h[21:17] || o_rt !== h[16:12] || o_sh !== h[11:7] || o_al !== h[6:2] || o_imm !== e_imm || o_tgt !== {37'd0, h[26:0]}) begin
          bad++; $display("FAIL rand%0d_c%0d_entry: ctrl=%h ill=%b imm=%h tgt=%h want word %h", use_b, c, o_ctrl, o_ill, o_imm, o_tgt, h);
        end
      end else begin
        total++; if (o_ctrl !== 11'd0) begin bad++; $display("FAIL rand%0d_c%0d_idle_ctrl: got %h want 0", use_b, c, o_ctrl); end
      end
      in_x  = iv && exp_rdy;
      out_x = (q.size() > 0) && ordy;
      @(posedge clk);
      if (in_x && ref_ctrl(w) == 11'd0 && m_cnt < cnt_max) m_cnt++;
      if (fl) q.delete();
      else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back(w);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal_sat();
    test_wide();
    test_flush();
    test_async_reset();
    test_no_skid();
    test_random(1'b0, 500);
    test_random(1'b1, 500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width for imm/target outputs; legal values are 32 or greater.
REQ-002 Parameter CNT_W, default 8, meaning width of the saturating illegal-opcode counter.
REQ-003 Parameter SKID_EN, default 1, meaning 1 = two-entry skid buffer, 0 = single output register only.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  stage can accept an instruction this cycle.
REQ-009 insn  input  32  instruction word: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm[16:0], target[26:0].
REQ-010 out_valid  output  1  decoded entry valid.
REQ-011 out_ready  input  1  downstream accepts the entry.
REQ-012 ctrl  output  11  one-hot class: {setx,bex,blt,jr,jal,bne,j,lw,sw,addi,rtype}, bit0 = rtype.
REQ-013 illegal  output  1  the presented entry has an unlisted opcode.
REQ-014 rd, rs, rt, shamt, aluop  output  5 each  raw fields of the held instruction.
REQ-015 imm  output  XLEN  imm[16:0] sign-extended.
REQ-016 target  output  XLEN  target[26:0] zero-extended.
REQ-017 illegal_cnt  output  CNT_W  count of illegal instructions accepted since reset.

Function
REQ-018 Opcode map: rtype 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
REQ-019 Any other opcode drives ctrl = 0 and illegal = 1; a legal opcode drives exactly one ctrl bit high and illegal = 0.
REQ-020 Decode is registered, so an instruction accepted in cycle N is presented at the outputs no earlier than cycle N+1.
REQ-021 Transfers: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-022 Occupancy states: EMPTY (0 entries), ONE (main register valid), FULL (main and skid valid); FULL exists only when SKID_EN = 1.
REQ-023 EMPTY -> ONE on input transfer.
REQ-024 ONE: input and output transfer together keep ONE and load the new entry into main; output transfer only -> EMPTY; input transfer only -> FULL, with the new entry loaded into skid.
REQ-025 FULL: output transfer moves skid into main -> ONE; no input transfer is possible in FULL.
REQ-026 With SKID_EN = 1, in_ready = 1 unless FULL, and in_ready is driven from a register with no combinational path from out_ready.
REQ-027 With SKID_EN = 0, in_ready = !out_valid || out_ready.
REQ-028 With SKID_EN = 0, input and output transfer in the same cycle replace the main entry.
REQ-029 Every output field is driven from the main entry, and each field is held stable while out_valid && !out_ready.
REQ-030 Entries leave in acceptance order; no entry is duplicated or lost except by flush.
REQ-031 Flush has priority over every other event: next state is EMPTY, and any input transfer in the flush cycle is discarded.
REQ-032 An output transfer in the flush cycle is still counted as delivered.
REQ-033 illegal_cnt increments by 1 on each accepted illegal instruction, including one later flushed, and saturates at all-ones without wrapping.
REQ-034 illegal_cnt is not cleared by flush.
REQ-035 Fields of a non-valid entry are don't-care, but the bench checks ctrl = 0 whenever out_valid = 0.

Reset
REQ-036 While reset is high, the block is in EMPTY: out_valid = 0, ctrl = 0, illegal = 0, illegal_cnt = 0, and all field outputs = 0.
REQ-037 in_ready = 0 while reset is high, and in_ready = 1 from the first clock edge after reset deasserts.
REQ-038 A reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Verification
REQ-039 Scenario: with out_ready = 1, insn 0x28400005 (addi rd=1) -> the next cycle shows out_valid = 1, ctrl = 11'h002, rd = 1, imm = 5.
REQ-040 Scenario: out_ready = 0 while three instructions are offered back-to-back -> two are accepted, in_ready = 0 on the third, and raising out_ready delivers them in order.
REQ-041 Scenario: with CNT_W = 2, five opcode-11111 instructions -> five entries with illegal = 1, ctrl = 0, and illegal_cnt ending at 3.
REQ-042 Scenario: imm field 17'h1FFFF with XLEN = 64 -> imm = all-ones; target field 27'h4000000 -> target = 64'h4000000.
REQ-043 Scenario: in state FULL, flush together with in_valid -> out_valid = 0 and in_ready = 1 next cycle, and neither the offered instruction nor any prior entry ever appears at the outputs.
REQ-044 Scenario: reset pulsed asynchronously between clock edges while FULL -> out_valid = 0 and illegal_cnt = 0 before the next edge.
